// File: rtl/riscv_pkg.sv
// Shared RV32 encoder types: instruction formats, opcodes, error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  // True when the immediate, read as signed, lies within [lo, hi].
  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/result bundle between an encode requester and the instruction-memory writer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request side and the word side.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;

  // Requester / memory-writer side.
  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, err_valid, err_code
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, err_valid, err_code
  );
endinterface

// File: rtl/inst_pack.sv
// Packs instruction fields into a 32-bit RV32 word and flags illegal requests.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic [1:0]  o_err_code
);

  // Field placement per format; checks ordered fmt, then range, then alignment.
  always_comb begin
    o_inst     = '0;
    o_err_code = ERR_NONE;
    case (i_fmt)
      FMT_R: begin
        o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_I: begin
        o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (!imm_in_range(i_imm, -2048, 2047)) o_err_code = ERR_RANGE;
      end
      FMT_ISH: begin
        o_inst = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (i_imm[31:5] != '0) o_err_code = ERR_RANGE;
      end
      FMT_S: begin
        o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        if (!imm_in_range(i_imm, -2048, 2047)) o_err_code = ERR_RANGE;
      end
      FMT_B: begin
        o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], i_opcode};
        // 4095 is odd but is reported as a range error since range wins.
        if (!imm_in_range(i_imm, -4096, 4094)) o_err_code = ERR_RANGE;
        else if (i_imm[0])                       o_err_code = ERR_ALIGN;
      end
      default: begin
        o_err_code = ERR_FMT;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Encodes instruction requests into addressed 32-bit words for an instruction-memory writer.
// Latency: 1 cycle from request acceptance to out_valid (or err_valid pulse).
// Backpressure: single output register; in_ready = !out_valid || out_ready, word held while stalled.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int MEM_DEPTH = 256  // power of two, >= 2
) (
  input logic          clk,
  input logic          reset,
  inst_encoder_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [AW-1:0] r_widx;       // word index of the held / next word
  logic          r_out_valid;
  logic [31:0]   r_out_inst;
  logic          r_err_valid;
  logic [1:0]    r_err_code;

  logic [31:0]   w_inst;
  logic [1:0]    w_err_code;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_out_fire;

  inst_pack u_pack (
    .i_fmt      (bus.in_fmt),
    .i_opcode   (bus.in_opcode),
    .i_funct3   (bus.in_funct3),
    .i_funct7   (bus.in_funct7),
    .i_rd       (bus.in_rd),
    .i_rs1      (bus.in_rs1),
    .i_rs2      (bus.in_rs2),
    .i_imm      (bus.in_imm),
    .o_inst     (w_inst),
    .o_err_code (w_err_code)
  );

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

  // Output word register: load on legal accept, clear once drained, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
    end else if (w_accept && (w_err_code == ERR_NONE)) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= w_inst;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // One-cycle error pulse for each rejected (but consumed) request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else if (w_accept && (w_err_code != ERR_NONE)) begin
      r_err_valid <= 1'b1;
      r_err_code  <= w_err_code;
    end else begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end
  end

  // Word index advances only when a word leaves; wraps naturally at MEM_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_widx <= '0;
    end else if (w_out_fire) begin
      r_widx <= r_widx + 1'b1;
    end
  end

  // out_addr follows the counter, so a word loaded on the same edge as a
  // drain automatically picks up the incremented address.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_inst  = r_out_inst;
  assign bus.out_addr  = 32'({r_widx, 2'b00});
  assign bus.err_valid = r_err_valid;
  assign bus.err_code  = r_err_code;

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter MEM_DEPTH, default 256: instruction-memory depth in 32-bit words; a power of two, at least 2.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  an encode request is present.
REQ-005 in_ready  output  1  the block accepts a request this cycle.
REQ-006 in_fmt  input  3  format: FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B (enum).
REQ-007 in_opcode  input  7  opcode field, placed at bits 6:0.
REQ-008 in_funct3, in_funct7  input  3 / 7  function fields.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  32  signed immediate (shift amount for FMT_ISH).
REQ-011 out_valid  output  1  out_inst/out_addr hold a valid word.
REQ-012 out_ready  input  1  downstream (instruction-memory writer) accepts the word.
REQ-013 out_inst  output  32  encoded instruction.
REQ-014 out_addr  output  32  byte address of out_inst.
REQ-015 err_valid  output  1  one-cycle pulse: the request accepted in the previous cycle was rejected.
REQ-016 err_code  output  2  0 none, 1 immediate out of range, 2 branch offset misaligned, 3 illegal in_fmt.

Function
REQ-017 Request accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, no combinational in_valid-to-out_valid path).
REQ-018 Latency: a valid request accepted in cycle N has out_valid high in cycle N+1.
REQ-019 out_inst, out_addr and out_valid hold stable while out_valid && !out_ready.
REQ-020 FMT_R: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored.
REQ-021 FMT_I: {imm[11:0], rs1, funct3, rd, opcode}; legal when -2048 <= imm <= 2047.
REQ-022 FMT_ISH: {funct7, imm[4:0], rs1, funct3, rd, opcode}; legal when imm[31:5] == 0.
REQ-023 FMT_S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; legal range as FMT_I.
REQ-024 FMT_B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; legal when -4096 <= imm <= 4094 and imm[0] == 0.
REQ-025 Check order: illegal fmt (code 3), then range (code 1), then alignment (code 2); the first failing check sets err_code.
REQ-026 A rejected request is consumed; in the next cycle err_valid = 1 with err_code set; no word is emitted; the address counter is unchanged.
REQ-027 err_valid is high for exactly one cycle per rejected request; err_code is 0 whenever err_valid = 0.
REQ-028 Address counter starts at 0 and advances by 4 on each out_valid && out_ready.
REQ-029 Wrap: after the word at 4*(MEM_DEPTH-1), the counter wraps to 0.
REQ-030 Simultaneous output handshake and new acceptance: the new word is loaded with the incremented address in the same edge; no bubble.

Reset
REQ-031 Reset clears out_valid, err_valid, err_code, out_inst and the address counter to 0; in_ready = 1 in the first cycle after reset.
REQ-032 Reset asserted mid-transfer drops any held word and any pending error without emitting it; reset has priority over every handshake.

Structure
REQ-033 Format enum, opcode constants and err_code constants are defined in the shared package riscv_pkg.
REQ-034 Field packing and legality checks form one combinational sub-module, inst_pack (fields in; word and err_code out); inst_encoder holds the handshake, output register and address counter.

Verification
REQ-035 Encode addi: FMT_I, opcode 0x13, rd 1, rs1 0, f3 0, imm 5 -> out_inst 0x00500093, out_addr 0, one cycle later.
REQ-036 Encode sw then beq: FMT_S, opcode 0x23, f3 2, rs2 2, rs1 0, imm 8 -> 0x00202423 at addr 0; then FMT_B, opcode 0x63, f3 0, imm -4 -> 0xFE000EE3 at addr 4.
REQ-037 Encode slli: FMT_ISH, opcode 0x13, f3 1, rd 1, rs1 1, f7 0, imm 3 -> 0x00309093; the same request with imm 32 -> err_code 1, no word emitted.
REQ-038 FMT_B with imm 3 -> err_valid pulse, err_code 2, address counter unchanged; FMT_I with imm 2048 -> err_code 1.
REQ-039 Hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0 and out_inst stable; release -> back-to-back words with no bubble. With MEM_DEPTH 4, emit 5 words -> addresses 0, 4, 8, 12, 0.
REQ-040 Assert reset while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, out_addr = 0, in_ready = 1.
